// File: rtl/buffer_register_fifo_if.sv
// Handshake bundle for buffer_register_fifo: producer side, consumer side,
// flush control and status. The FIFO uses the slave view; whatever drives
// the FIFO (producer/consumer pair or a bench) uses the master view.
interface buffer_register_fifo_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              almost_full;
    logic              full;
    logic              empty;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, almost_full, full, empty
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, almost_full, full, empty
    );
endinterface

// File: rtl/buffer_register_fifo.sv
// DEPTH-entry, DATA_W-bit first-word-fall-through circular buffer with
// valid/ready on both sides, occupancy count, almost-full flag and a
// synchronous flush. Pointers wrap by explicit compare, so DEPTH need not
// be a power of two.
module buffer_register_fifo #(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   reset,
    buffer_register_fifo_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;

    // Advance a pointer, returning to slot 0 after the last real entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Transfers happen only on a completed handshake; flags come straight
    // from the registered count so they never glitch within a cycle.
    always_comb begin
        push            = bus.in_valid  && bus.in_ready;
        pop             = bus.out_valid && bus.out_ready;
        bus.full        = (count_q == CNT_W'(DEPTH));
        bus.empty       = (count_q == '0);
        bus.almost_full = (count_q >= CNT_W'(AF_THRESH));
        bus.in_ready    = !bus.full;
        bus.out_valid   = !bus.empty;
        bus.out_data    = mem[rd_ptr];
        bus.count       = count_q;
    end

    // Storage write; a flush in the same cycle discards the incoming word.
    // NOTE: the array is in the async reset on purpose so out_data reads 0,
    // never X, right after reset; that costs a reset net per storage bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !bus.flush) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush overrides any push or pop.
    // NOTE: non-blocking assignments here so every update reads the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: doc/buffer_register_fifo.md
Name: buffer_register_fifo

Overview:
- Parametrised successor to the single-stage 4-bit buffer register: a DEPTH-entry, DATA_W-bit circular buffer.
- Uses valid/ready handshakes on both sides, first-word-fall-through output, occupancy count, an almost-full flag and a synchronous flush.
- Sits between a producer and consumer running on the same clock, decoupling short bursts and back-pressure.

Parameters:
- DATA_W, 4, width of each data word.
- DEPTH, 4, number of storage entries; any integer >= 2 (not restricted to powers of two).
- AF_THRESH, DEPTH-1, occupancy at or above which almost_full asserts; legal range 1..DEPTH.
- CNT_W, $clog2(DEPTH+1), width of count output; derived, not overridden.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- flush  input  1  synchronous clear of contents.
- in_valid  input  1  producer offers in_data this cycle.
- in_data  input  DATA_W  write data.
- in_ready  output  1  buffer can accept a word this cycle.
- out_valid  output  1  out_data holds the oldest stored word.
- out_data  output  DATA_W  oldest stored word (FWFT).
- out_ready  input  1  consumer takes out_data this cycle.
- count  output  CNT_W  number of stored words, 0..DEPTH.
- almost_full  output  1  count >= AF_THRESH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (async, active-high): wr_ptr=0, rd_ptr=0, count=0. Outputs during and after reset: in_ready=1, out_valid=0, empty=1, full=0, almost_full=0 (AF_THRESH>=1), out_data=0. Storage array is also cleared to 0.
- Push: occurs when in_valid && in_ready at the rising edge. mem[wr_ptr]<=in_data; wr_ptr advances.
- Pop: occurs when out_valid && out_ready at the rising edge. rd_ptr advances.
- Pointer wrap: a pointer equal to DEPTH-1 returns to 0 on advance, with an explicit compare (no reliance on power-of-two overflow).
- in_ready = !full. out_valid = !empty. out_data = mem[rd_ptr] (combinational from registered state). out_data is don't-care when out_valid=0 but must hold its last value, not X, after reset.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N; earliest pop at edge N+1. There is no same-cycle input-to-output bypass.
- count update:
  - push only: +1
  - pop only: -1
  - both: unchanged, both pointers advance
  - neither: unchanged
- Full: in_ready=0, so no push is possible; a pop in the same cycle frees a slot visible next cycle only. in_valid held high while full is legal and causes no error; data is retained by the producer.
- Empty: out_valid=0, so out_ready is ignored. A push when empty makes out_valid=1 next cycle.
- Flush: synchronous and highest priority. On the flush edge, pointers and count return to 0 regardless of in_valid/out_ready. Any push or pop in the same cycle is discarded and not counted. Storage contents need not be cleared.
- Reset asserted mid-burst: all state is cleared immediately, without waiting for a clock edge. Any word in flight is lost. After deassertion the first push lands at mem[0].
- Flags full, empty and almost_full are combinational decodes of the registered count; they are glitch-free relative to clk.
- Order: strict FIFO. No word is ever duplicated, dropped (except by flush/reset) or reordered.

Test Plan (DATA_W=4, DEPTH=4, AF_THRESH=3):
- Reset, then push 0101 with out_ready=0 -> next cycle out_valid=1, out_data=0101, count=1, empty=0.
- Push 0101,1010,1111,0011 back-to-back, out_ready=0 -> count steps 1,2,3,4; almost_full rises at count=3; full=1 and in_ready=0 at count=4. A fifth in_valid with 1100 is not accepted.
- From full, out_ready=1 and in_valid=1 with 1100 -> cycle 1: pop 0101 only, count=3. Next cycle: push and pop together, count stays 3. Output order is 1010,1111,0011,1100, exercising rd_ptr and wr_ptr wrap 3->0.
- Continuous stream with in_valid=out_ready=1 for 10 cycles, data 0..9 -> count stays 1 after the first push; outputs 0..9 appear in order one cycle after input.
- Load 3 words, assert flush together with in_valid=1 (data 0111) and out_ready=1 -> next cycle count=0, empty=1, out_valid=0, and 0111 is never output.
- Load 2 words, assert reset between clock edges -> out_valid=0 and count=0 before the next edge. After release, push 1001; out_data=1001 next cycle.
